// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle between the core pipeline and hazard_ctrl.
// The core (master) drives the decode/execute status and consumes the
// forward/stall/flush controls. The hazard controller is the slave.
// Optional macro HAZARD_PERF_EN adds the two performance counter outputs.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic [REG_AW-1:0] rd_id;
  logic              reg_we_id;
  logic              load_id;
  logic              redirect_exe;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              bubble_exe;
  logic [1:0]        state_dbg;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_id, redirect_exe,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, bubble_exe, state_dbg,
    input  perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_id, redirect_exe,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, bubble_exe, state_dbg,
    output perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_id, redirect_exe,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, bubble_exe, state_dbg
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_id, redirect_exe,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, bubble_exe, state_dbg
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Keeps a shadow copy of the producers in EXE and MEM, registers the operand
// forward selects one cycle ahead of execute, inserts a single bubble on a
// load-use dependency and sequences the IF/ID flush after an EXE redirect.
// The forward selects are computed while the consumer is still in ID, so the
// shadow MEM entry seen then is the WB producer by the time the consumer
// executes; no separate WB shadow entry is needed for that reason.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Remaining flush cycles after the redirect cycle itself.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t            state_r, state_next;
  logic [1:0]        cnt_r, cnt_next;
  logic              stall_s, flush_s, load_use_s;
  logic [1:0]        fwd_a_s, fwd_b_s;
  logic [1:0]        fwd_a_r, fwd_b_r;

  logic              exe_valid_r, exe_we_r, exe_load_r;
  logic [REG_AW-1:0] exe_rd_r;
  logic              mem_valid_r, mem_we_r;
  logic [REG_AW-1:0] mem_rd_r;

  // A producer only matches when it is live, writes, and does not target x0.
  function automatic logic rd_match(input logic v, input logic we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
    return v && we && (rd != {REG_AW{1'b0}}) && (rd == rs);
  endfunction

  // Youngest producer wins; a load in EXE cannot forward its ALU result.
  function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    if (rd_match(exe_valid_r, exe_we_r, exe_rd_r, rs) && !exe_load_r) begin
      sel = 2'd1;
    end else if (rd_match(mem_valid_r, mem_we_r, mem_rd_r, rs)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Load in EXE feeding a source of the instruction currently in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (hz.id_valid && exe_load_r) begin
      load_use_s = rd_match(exe_valid_r, exe_we_r, exe_rd_r, hz.rs1_id) ||
                   rd_match(exe_valid_r, exe_we_r, exe_rd_r, hz.rs2_id);
    end else begin
      load_use_s = 1'b0;
    end
  end

  // FSM next state, flush counter and combinational stall/flush controls.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    stall_s    = 1'b0;
    flush_s    = 1'b0;
    if (rst) begin
      state_next = RUN;
      cnt_next   = 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.redirect_exe) begin
            flush_s    = 1'b1;
            cnt_next   = FLUSH_RELOAD;
            state_next = (FLUSH_RELOAD == 2'd0) ? RUN : FLUSH;
          end else if (load_use_s) begin
            stall_s    = 1'b1;
            state_next = STALL;
          end else begin
            state_next = RUN;
          end
        end
        STALL: begin
          if (hz.redirect_exe) begin
            flush_s    = 1'b1;
            cnt_next   = FLUSH_RELOAD;
            state_next = (FLUSH_RELOAD == 2'd0) ? RUN : FLUSH;
          end else begin
            state_next = RUN;
          end
        end
        FLUSH: begin
          flush_s = 1'b1;
          if (hz.redirect_exe) begin
            cnt_next   = FLUSH_RELOAD;
            state_next = (FLUSH_RELOAD == 2'd0) ? RUN : FLUSH;
          end else if (cnt_r <= 2'd1) begin
            cnt_next   = 2'd0;
            state_next = RUN;
          end else begin
            cnt_next   = cnt_r - 2'd1;
            state_next = FLUSH;
          end
        end
        default: begin
          cnt_next   = 2'd0;
          state_next = RUN;
        end
      endcase
    end
  end

  // Forward selects for the instruction about to enter EXE.
  always_comb begin
    fwd_a_s = 2'd0;
    fwd_b_s = 2'd0;
    if (hz.id_valid && !stall_s && !flush_s) begin
      fwd_a_s = fwd_pick(hz.rs1_id);
      fwd_b_s = fwd_pick(hz.rs2_id);
    end else begin
      fwd_a_s = 2'd0;
      fwd_b_s = 2'd0;
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
    end
  end

  // Shadow pipeline and registered forward selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid_r <= 1'b0;
      exe_we_r    <= 1'b0;
      exe_load_r  <= 1'b0;
      exe_rd_r    <= {REG_AW{1'b0}};
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_rd_r    <= {REG_AW{1'b0}};
      fwd_a_r     <= 2'd0;
      fwd_b_r     <= 2'd0;
    end else begin
      mem_valid_r <= exe_valid_r;
      mem_we_r    <= exe_we_r;
      mem_rd_r    <= exe_rd_r;
      if (stall_s || flush_s) begin
        exe_valid_r <= 1'b0;
        exe_we_r    <= 1'b0;
        exe_load_r  <= 1'b0;
        exe_rd_r    <= {REG_AW{1'b0}};
      end else begin
        exe_valid_r <= hz.id_valid;
        exe_we_r    <= hz.reg_we_id;
        exe_load_r  <= hz.load_id;
        exe_rd_r    <= hz.rd_id;
      end
      fwd_a_r <= fwd_a_s;
      fwd_b_r <= fwd_b_s;
    end
  end

  assign hz.fwd_a_sel  = fwd_a_r;
  assign hz.fwd_b_sel  = fwd_b_r;
  assign hz.stall_if   = stall_s;
  assign hz.stall_id   = stall_s;
  assign hz.flush_id   = flush_s;
  assign hz.bubble_exe = stall_s || flush_s;
  assign hz.state_dbg  = state_r;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_r, perf_flush_r;

  // Saturating counts of stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush_s && (perf_flush_r != 32'hFFFF_FFFF)) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_r;
  assign hz.perf_flush_cnt = perf_flush_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use stall, redirect flush,
// redirect/load-use priority and asynchronous reset during a flush.
// Expected forward selects are queued when an ID instruction is driven and
// compared one cycle later when that instruction sits in EXE.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl_if #(.REG_AW(5)) hz ();

  hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_fwd();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_fwd_a"}, 32'(hz.fwd_a_sel), 32'(e.a));
      chk({e.tag, "_fwd_b"}, 32'(hz.fwd_b_sel), 32'(e.b));
    end
  endtask

  // One cycle, entered at posedge+1: check the previous forward, drive ID,
  // check the combinational controls, queue this instruction's forward.
  task automatic step(input string tag, input logic v,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic rdr,
                      input logic e_stall, input logic e_flush, input logic [1:0] e_state,
                      input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    pop_fwd();
    hz.id_valid     = v;
    hz.rs1_id       = r1;
    hz.rs2_id       = r2;
    hz.rd_id        = rd;
    hz.reg_we_id    = we;
    hz.load_id      = ld;
    hz.redirect_exe = rdr;
    #1;
    chk({tag, "_stall_if"}, 32'(hz.stall_if), 32'(e_stall));
    chk({tag, "_stall_id"}, 32'(hz.stall_id), 32'(e_stall));
    chk({tag, "_flush_id"}, 32'(hz.flush_id), 32'(e_flush));
    chk({tag, "_bubble"}, 32'(hz.bubble_exe), 32'(e_stall | e_flush));
    chk({tag, "_state"}, 32'(hz.state_dbg), 32'(e_state));
    e.tag = tag;
    e.a   = e_fa;
    e.b   = e_fb;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall_if"}, 32'(hz.stall_if), 32'd0);
    chk({tag, "_stall_id"}, 32'(hz.stall_id), 32'd0);
    chk({tag, "_flush_id"}, 32'(hz.flush_id), 32'd0);
    chk({tag, "_bubble"}, 32'(hz.bubble_exe), 32'd0);
    chk({tag, "_fwd_a"}, 32'(hz.fwd_a_sel), 32'd0);
    chk({tag, "_fwd_b"}, 32'(hz.fwd_b_sel), 32'd0);
    chk({tag, "_state"}, 32'(hz.state_dbg), 32'd0);
`ifdef HAZARD_PERF_EN
    chk({tag, "_perf_stall"}, hz.perf_stall_cnt, 32'd0);
    chk({tag, "_perf_flush"}, hz.perf_flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    hz.id_valid     = 1'b0;
    hz.rs1_id       = 5'd0;
    hz.rs2_id       = 5'd0;
    hz.rd_id        = 5'd0;
    hz.reg_we_id    = 1'b0;
    hz.load_id      = 1'b0;
    hz.redirect_exe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    //            tag    v     rs1    rs2    rd     we    ld    rdr   stall flush state  fa     fb
    // ALU forward: ADD x5, then ADD x6,x5,x1
    step("c1",  1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c2",  1'b1, 5'd5,  5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    // Youngest producer wins: x5 in both EXE and MEM
    step("c3",  1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c4",  1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c5",  1'b1, 5'd3,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1);
    // EXE entry writes x0, MEM holds x5 -> MEM forward
    step("c6",  1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c7",  1'b1, 5'd4,  5'd5,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2);
    // Load-use: LW x7 then consumer of x7, one stall cycle then MEM forward
    step("c8",  1'b1, 5'd2,  5'd0,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c9",  1'b1, 5'd7,  5'd1,  5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c10", 1'b1, 5'd7,  5'd1,  5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0);
    step("c11", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    // Redirect: two flush cycles, forwards forced to 0
    step("c12", 1'b1, 5'd10, 5'd0,  5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
    step("c13", 1'b1, 5'd11, 5'd0,  5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    step("c14", 1'b1, 5'd0,  5'd0,  5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    // Load-use coinciding with redirect: flush wins, no stall
    step("c15", 1'b1, 5'd0,  5'd0,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c16", 1'b1, 5'd7,  5'd0,  5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
    step("c17", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    step("c18", 1'b1, 5'd7,  5'd0,  5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    // Redirect while flushing reloads the counter
    step("c19", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
    step("c20", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    step("c21", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    step("c22", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", hz.perf_stall_cnt, 32'd1);
    chk("perf_flush", hz.perf_flush_cnt, 32'd7);
`endif
    // Asynchronous reset in the middle of a flush
    step("c23", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
    pop_fwd();
    hz.redirect_exe = 1'b0;
    #1;
    chk("mid_flush_state", 32'(hz.state_dbg), 32'd2);
    chk("mid_flush_flush", 32'(hz.flush_id), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Normal forwarding resumes after reset
    step("c24", 1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("c25", 1'b1, 5'd5,  5'd0,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    step("c26", 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    pop_fwd();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core (IF/ID/EXE/MEM/WB).
- Tracks destination registers of instructions in EXE, MEM and WB in its own shadow pipeline.
- Produces registered forwarding selects consumed by the execute stage's operand muxes.
- Detects load-use hazards, stalls IF/ID with a bubble, and sequences flushes after taken branches/jumps resolved in EXE.

Parameters:
- REG_AW, 5, register address width.
- FLUSH_CYCLES, 2, cycles of flush asserted after a redirect (1..3).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode stage holds a valid instruction.
- rs1_id  in  REG_AW  decode rs1 address.
- rs2_id  in  REG_AW  decode rs2 address.
- rd_id  in  REG_AW  decode rd address.
- reg_we_id  in  1  decode instruction writes rd.
- load_id  in  1  decode instruction is a load.
- redirect_exe  in  1  taken branch or jump resolved in EXE (br_true qualified by branch/jump decode).
- fwd_a_sel  out  2  EXE operand A forward: 0 none, 1 ALU (MEM-stage result), 2 MEM (WB data).
- fwd_b_sel  out  2  same encoding for operand B.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  invalidate IF/ID register.
- bubble_exe  out  1  inject NOP into ID/EXE register.
- state_dbg  out  2  current FSM state.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM=RUN, shadow pipeline valid bits cleared, flush counter 0.
- Shadow pipeline: per stage {valid, rd, we, load} for EXE, MEM, WB. Advances every cycle unless stalled. On stall, EXE gets a bubble (valid=0) while MEM/WB advance. On flush, the entry entering EXE is invalidated.
- Hazard ignore: rd==0 or we==0 never matches.
- Forward select (registered, valid in the cycle the instruction sits in EXE):
  - A source matching EXE-stage rd (not load) selects ALU (1).
  - Else a source matching MEM-stage rd selects MEM (2).
  - Else 0. Youngest producer wins.
  - Computed only for id_valid=1 and not stalling; forced 0 on bubble or flush.
- Load-use: EXE entry is a valid load with rd==rs1_id or rd==rs2_id (rs used), and id_valid=1. Assert stall_if, stall_id and bubble_exe combinationally in that cycle. The next cycle the load is in MEM and the dependent instruction re-evaluates to fwd=2. Exactly one stall cycle per load-use.
- FSM states:
  - RUN: normal operation.
    - RUN -> STALL on load-use with no redirect.
    - RUN -> FLUSH on redirect_exe.
  - STALL: one cycle; stall outputs are 0 again. Always returns to RUN, or goes to FLUSH if redirect_exe.
  - FLUSH: flush_id=1 and bubble_exe=1 for FLUSH_CYCLES total, counted from the redirect cycle. Stalls are suppressed. Returns to RUN when the counter expires. A new redirect_exe while in FLUSH reloads the counter.
- Simultaneous redirect and load-use: redirect wins; no stall is asserted and the dependent instruction is flushed.
- Reset mid-flush or mid-stall: immediate return to RUN with all outputs 0.

Optional Feature:
- HAZARD_PERF_EN: adds 32-bit saturating counters plus output ports:
  - perf_stall_cnt (32): counts cycles with stall_if=1.
  - perf_flush_cnt (32): counts cycles with flush_id=1.
- Counters reset to 0 and saturate at 0xFFFFFFFF.
- Without the macro: no counters, no ports; all other behaviour is identical.

Test Plan:
- ADD x5 in EXE, then ADD x6,x5,x1 in ID -> next cycle fwd_a_sel=1, fwd_b_sel=0, no stall.
- ADD x5 in MEM and ADD x5 in EXE, ID reads rs2=x5 -> fwd_b_sel=1 (youngest wins). With EXE entry rd=x0 instead -> fwd_b_sel=2.
- LW x7 in EXE, ID reads rs1=x7 -> stall_if=stall_id=bubble_exe=1 for exactly 1 cycle, then fwd_a_sel=2.
- redirect_exe=1 with FLUSH_CYCLES=2 -> flush_id=bubble_exe=1 for 2 cycles, state RUN->FLUSH->RUN, forwards 0 during flush.
- Load-use and redirect_exe in the same cycle -> no stall, flush_id=1, state FLUSH.
- rst pulsed during FLUSH (asynchronous, between edges) -> all outputs 0 immediately, state_dbg=RUN. With HAZARD_PERF_EN, counters read 0.
